// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - forwarding encodings, hazard FSM states and stage record for pipe_hazard_ctrl
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMO  = 2'b11;

    // Register numbers are zero-extended into a fixed-width record field,
    // so REG_W may be anything up to REC_RN_W.
    localparam int REC_RN_W = 8;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        INTERLOCK = 2'd1,
        MEMWAIT   = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic                valid;
        logic                wreg;
        logic                m2reg;
        logic [REC_RN_W-1:0] rn;
    } stage_rec_t;

    localparam stage_rec_t REC_EMPTY = '0;

    // A stage produces operand r only if it really writes a non-zero register that is read.
    function automatic logic rec_match(input stage_rec_t rec,
                                       input logic [REC_RN_W-1:0] r,
                                       input logic use_r);
        return use_r && rec.valid && rec.wreg && (rec.rn == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - operand forwarding select for one ID source operand
module fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  stage_rec_t       e_rec,
    input  stage_rec_t       m_rec,
    input  logic [REG_W-1:0] r,
    input  logic             use_r,
    output logic [1:0]       sel
);

    logic [REC_RN_W-1:0] r_ext;
    logic                e_hit;
    logic                m_hit;

    assign r_ext = REC_RN_W'(r);
    assign e_hit = rec_match(e_rec, r_ext, use_r);
    assign m_hit = rec_match(m_rec, r_ext, use_r);

    // A load in EXE has no data yet; fall through to MEM, the load-use stall covers it.
    always_comb begin
        sel = FWD_RF;
        if (e_hit && !e_rec.m2reg) begin
            sel = FWD_EALU;
        end else if (m_hit && m_rec.m2reg) begin
            sel = FWD_MMO;
        end else if (m_hit) begin
            sel = FWD_MALU;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding, load-use interlock and memory-wait freeze; HAZARD_PERF_CNT_EN adds stall/freeze counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             d_wreg,
    input  logic             d_m2reg,
    input  logic [REG_W-1:0] d_rn,
    input  logic             m_ready,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             bubble,
    output logic             freeze
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      freeze_cnt
`endif
);

    stage_rec_t e_rec;
    stage_rec_t m_rec;
    stage_rec_t d_rec;
    hz_state_e  state;
    hz_state_e  state_nxt;

    logic use_a;
    logic use_b;
    logic e_hit_a;
    logic e_hit_b;
    logic load_use;
    logic mem_wait;

    assign use_a = d_valid & d_use_rs;
    assign use_b = d_valid & d_use_rt;

    always_comb begin
        d_rec       = REC_EMPTY;
        d_rec.valid = d_valid;
        d_rec.wreg  = d_wreg;
        d_rec.m2reg = d_m2reg;
        d_rec.rn    = REC_RN_W'(d_rn);
    end

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .e_rec (e_rec),
        .m_rec (m_rec),
        .r     (d_rs),
        .use_r (use_a),
        .sel   (fwda)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .e_rec (e_rec),
        .m_rec (m_rec),
        .r     (d_rt),
        .use_r (use_b),
        .sel   (fwdb)
    );

    assign e_hit_a  = rec_match(e_rec, REC_RN_W'(d_rs), use_a);
    assign e_hit_b  = rec_match(e_rec, REC_RN_W'(d_rt), use_b);
    assign load_use = e_rec.m2reg & (e_hit_a | e_hit_b);
    assign mem_wait = m_rec.valid & m_rec.m2reg & ~m_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory wait outranks load-use: a frozen EXE keeps the load, so the
    // interlock is simply re-evaluated once the memory completes.
    always_comb begin
        state_nxt = state;
        wpcir     = 1'b1;
        bubble    = 1'b0;
        freeze    = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    freeze    = 1'b1;
                    wpcir     = 1'b0;
                    state_nxt = MEMWAIT;
                end else if (load_use) begin
                    bubble    = 1'b1;
                    wpcir     = 1'b0;
                    state_nxt = INTERLOCK;
                end
            end
            INTERLOCK: begin
                // EXE now holds the bubble, so no second load-use can follow.
                if (mem_wait) begin
                    freeze    = 1'b1;
                    wpcir     = 1'b0;
                    state_nxt = MEMWAIT;
                end else begin
                    state_nxt = RUN;
                end
            end
            MEMWAIT: begin
                if (mem_wait) begin
                    freeze    = 1'b1;
                    wpcir     = 1'b0;
                end else if (load_use) begin
                    bubble    = 1'b1;
                    wpcir     = 1'b0;
                    state_nxt = INTERLOCK;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_rec <= REC_EMPTY;
            m_rec <= REC_EMPTY;
        end else if (!freeze) begin
            m_rec <= e_rec;
            e_rec <= bubble ? REC_EMPTY : d_rec;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (bubble) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (freeze) begin
                freeze_cnt <= freeze_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
